// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, FSM states and
// the instruction word layout.
package alu_seq_pkg;

  localparam int NREGS = 4;
  localparam int DW    = 4;
  localparam int RW    = 2;
  localparam int IW    = 11;

  localparam logic [1:0] OP_SRA = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  localparam int LI_BIT  = 10;
  localparam int OP_LSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RS_LSB  = 4;
  localparam int FLD_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } seqState_e;

  typedef struct packed {
    logic          li;
    logic [1:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs;
    logic [DW-1:0] field;
  } instr_t;

  function automatic instr_t decodeInstr(input logic [IW-1:0] raw);
    instr_t d;
    d.li    = raw[LI_BIT];
    d.op    = raw[OP_LSB +: 2];
    d.rd    = raw[RD_LSB +: RW];
    d.rs    = raw[RS_LSB +: RW];
    d.field = raw[FLD_LSB +: DW];
    return d;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x4-bit register file: two asynchronous read ports, one synchronous write
// port, cleared by the synchronous reset.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] rAddrA,
  output logic [DW-1:0] rDataA,
  input  logic [RW-1:0] rAddrB,
  output logic [DW-1:0] rDataB,
  input  logic          wEn,
  input  logic [RW-1:0] wAddr,
  input  logic [DW-1:0] wData
);

  logic [DW-1:0] regs_r [NREGS];

  // Register storage: reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wEn) begin
      regs_r[wAddr] <= wData;
    end
  end

  assign rDataA = regs_r[rAddrA];
  assign rDataB = regs_r[rAddrB];

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side sequencer for the 4-bit ALU: accepts one instruction, drives the
// ALU for a single cycle, writes the answer back and offers it downstream.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_c,
  output logic [1:0]    alu_op,
  input  logic [DW-1:0] alu_ans,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [RW-1:0] out_rd
);

  seqState_e     curState_r, nextState_s;
  instr_t        instrIn_s;
  logic [1:0]    op_r;
  logic [RW-1:0] rd_r, rs_r, rt_r;
  logic [DW-1:0] outData_r;
  logic [RW-1:0] outRd_r;
  logic [DW-1:0] rdA_s, rdB_s;
  logic          accept_s, we_s;
  logic [RW-1:0] wAddr_s;
  logic [DW-1:0] wData_s;
  logic [DW-1:0] aluA_s, aluB_s;
  logic [1:0]    aluC_s, aluOp_s;

  assign instrIn_s = decodeInstr(in_instr);

  alu_seq_regfile uRegs (
    .clk    (clk),
    .reset  (reset),
    .rAddrA (rs_r),
    .rDataA (rdA_s),
    .rAddrB (rt_r),
    .rDataB (rdB_s),
    .wEn    (we_s),
    .wAddr  (wAddr_s),
    .wData  (wData_s)
  );

  // Next-state, ALU drive and write-back selection.
  always_comb begin
    nextState_s = curState_r;
    accept_s    = 1'b0;
    we_s        = 1'b0;
    wAddr_s     = rd_r;
    wData_s     = alu_ans;
    aluA_s      = '0;
    aluB_s      = '0;
    aluC_s      = 2'b00;
    aluOp_s     = 2'b00;
    case (curState_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (instrIn_s.li) begin
            // Immediate loads bypass the ALU and retire straight into WB.
            nextState_s = WB;
            we_s        = 1'b1;
            wAddr_s     = instrIn_s.rd;
            wData_s     = instrIn_s.field;
          end else begin
            nextState_s = ISSUE;
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      ISSUE: begin
        aluOp_s     = op_r;
        aluA_s      = rdA_s;
        aluB_s      = rdB_s;
        aluC_s      = rt_r;
        we_s        = 1'b1;
        wAddr_s     = rd_r;
        wData_s     = alu_ans;
        nextState_s = WB;
      end
      WB: begin
        if (out_ready) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = WB;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // State, latched instruction fields and the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      curState_r <= IDLE;
      op_r       <= 2'b00;
      rd_r       <= '0;
      rs_r       <= '0;
      rt_r       <= '0;
      outData_r  <= '0;
      outRd_r    <= '0;
    end else begin
      curState_r <= nextState_s;
      if (accept_s) begin
        op_r <= instrIn_s.op;
        rd_r <= instrIn_s.rd;
        rs_r <= instrIn_s.rs;
        rt_r <= instrIn_s.field[RW-1:0];
      end
      if (we_s) begin
        outData_r <= wData_s;
        outRd_r   <= wAddr_s;
      end
    end
  end

  assign in_ready  = (curState_r == IDLE);
  assign out_valid = (curState_r == WB);
  assign out_data  = outData_r;
  assign out_rd    = outRd_r;
  assign alu_a     = aluA_s;
  assign alu_b     = aluB_s;
  assign alu_c     = aluC_s;
  assign alu_op    = aluOp_s;

endmodule
